dsc_mac_engine: RTL and testbench

Parametrised deterministic stochastic-computing arithmetic engine. It converts two WIDTH-bit binary operands into unary bitstreams using counter/comparator generators. It combines the streams LANES bits per cycle (AND for multiply/min, OR for max) and accumulates the result back to binary with a popcount-driven counter. It generalises the fixed 4-bit PRG, min/max gate and parallel-accumulator path into one handshaked, multi-mode, multi-lane block.

---
 rtl/dsc_mac_engine_pkg.sv | 13 +
 rtl/dsc_popcount.sv | 13 +
 rtl/dsc_mac_engine.sv | 77 +++++++
 tb/tb_dsc_mac_engine.sv | 127 ++++++++++++
 4 files changed

// File: rtl/dsc_mac_engine_pkg.sv
// dsc_mac_engine_pkg: shared mode/state encodings and width helper for the stochastic MAC engine
package dsc_mac_engine_pkg;
  localparam logic [1:0] MODE_MUL = 2'd0;
  localparam logic [1:0] MODE_MIN = 2'd1;
  localparam logic [1:0] MODE_MAX = 2'd2;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/dsc_popcount.sv
// dsc_popcount: combinational count of set bits across the lane vector
module dsc_popcount import dsc_mac_engine_pkg::*; #(
  parameter int LANES = 1
) (
  input  logic [LANES-1:0]      bits,
  output logic [clog2(LANES):0] count
);
  localparam int CW = clog2(LANES) + 1;
  always_comb begin
    count = '0;
    for (int i = 0; i < LANES; i++) count = count + CW'(bits[i]);
  end
endmodule

// File: rtl/dsc_mac_engine.sv
// dsc_mac_engine: deterministic unary-stream multiply/min/max engine with LANES bits per cycle
module dsc_mac_engine import dsc_mac_engine_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int LANES = 1,
  parameter int RES_W = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] result
);
  localparam int CW = clog2(LANES) + 1;
  localparam logic [WIDTH:0] STEP = (WIDTH + 1)'(LANES);
  state_t state, state_n;
  logic [WIDTH-1:0] a_lat, b_lat, fast, slow;
  logic [1:0] mode_lat;
  logic [RES_W-1:0] acc, acc_n;
  logic [LANES-1:0] lane_bits;
  logic [CW-1:0] pc;
  logic [WIDTH:0] fast_sum;
  logic is_mul, is_max, last;
  assign is_mul = mode_lat != MODE_MIN && mode_lat != MODE_MAX;
  assign is_max = mode_lat == MODE_MAX;
  assign fast_sum = {1'b0, fast} + STEP;
  // mul walks the full fast x slow grid; min/max need only one fast period
  assign last = fast_sum[WIDTH] && (!is_mul || &slow);
  assign acc_n = acc + RES_W'(pc);
  assign busy = state == RUN;
  assign done = state == DONE;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH:0] idx;
    logic sa, sb;
    assign idx = {1'b0, fast} + (WIDTH + 1)'(i);
    assign sa = {1'b0, a_lat} > idx;
    assign sb = is_mul ? b_lat > slow : {1'b0, b_lat} > idx;
    assign lane_bits[i] = is_max ? sa | sb : sa & sb;
  end
  dsc_popcount #(.LANES(LANES)) u_pc (.bits(lane_bits), .count(pc));
  always_comb begin
    state_n = state == IDLE ? (start ? RUN : IDLE)
            : state == RUN  ? (abort ? IDLE : last ? DONE : RUN)
            : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      a_lat    <= '0;
      b_lat    <= '0;
      mode_lat <= '0;
      fast     <= '0;
      slow     <= '0;
      acc      <= '0;
      result   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        a_lat    <= a;
        b_lat    <= b;
        mode_lat <= mode;
        fast     <= '0;
        slow     <= '0;
        acc      <= '0;
      end else if (state == RUN && !abort) begin
        fast <= fast_sum[WIDTH-1:0];
        slow <= slow + WIDTH'(fast_sum[WIDTH]);
        acc  <= acc_n;
        if (last) result <= acc_n;
      end
    end
  end
endmodule

// File: tb/tb_dsc_mac_engine.sv
// tb_dsc_mac_engine: directed plus random checks of a LANES=1 and a LANES=4 engine against an arithmetic model
module tb_dsc_mac_engine;
  logic clk = 0, rst = 0, start = 0, ab0 = 0, ab4 = 0;
  logic [1:0] mode = 0;
  logic [3:0] a = 0, b = 0;
  logic busy0, done0, busy4, done4;
  logic [7:0] res0, res4;
  int cmp = 0, errs = 0;

  always #5 clk = ~clk;

  dsc_mac_engine #(.WIDTH(4), .LANES(1), .RES_W(8)) u0 (
    .clk(clk), .rst(rst), .start(start), .abort(ab0), .mode(mode), .a(a), .b(b),
    .busy(busy0), .done(done0), .result(res0));
  dsc_mac_engine #(.WIDTH(4), .LANES(4), .RES_W(8)) u4 (
    .clk(clk), .rst(rst), .start(start), .abort(ab4), .mode(mode), .a(a), .b(b),
    .busy(busy4), .done(done4), .result(res4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int model(input int x, input int y, input int m);
    if (m == 1) return x < y ? x : y;
    if (m == 2) return x > y ? x : y;
    return x * y;
  endfunction

  function automatic int cycles(input int m, input int l);
    return (m == 1 || m == 2) ? 16 / l : 256 / l;
  endfunction

  task automatic go(input logic [3:0] ta, input logic [3:0] tb_, input logic [1:0] tm);
    @(negedge clk);
    a = ta; b = tb_; mode = tm; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] ta, input logic [3:0] tb_,
                        input logic [1:0] tm, input int ign);
    int bc0, bc4, dc0, dc4, at0, at4, e;
    logic [7:0] r0, r4;
    bc0 = 0; bc4 = 0; dc0 = 0; dc4 = 0; at0 = -1; at4 = -1; r0 = 'x; r4 = 'x;
    e = model(int'(ta), int'(tb_), int'(tm));
    go(ta, tb_, tm);
    for (int c = 0; c < 700; c++) begin
      if (busy0) bc0++;
      if (busy4) bc4++;
      if (done0) begin dc0++; at0 = bc0; r0 = res0; end
      if (done4) begin dc4++; at4 = bc4; r4 = res4; end
      start = (c == ign);
      if (c == ign) begin a = 4'd1; b = 4'd1; mode = 2'd0; end
      if (dc0 > 0 && dc4 > 0) break;
      @(negedge clk);
    end
    start = 0;
    chk({tag, "_res1"}, r0, e);
    chk({tag, "_res4"}, r4, e);
    chk({tag, "_busy1"}, bc0, cycles(int'(tm), 1));
    chk({tag, "_busy4"}, bc4, cycles(int'(tm), 4));
    chk({tag, "_donecyc1"}, at0, cycles(int'(tm), 1));
    chk({tag, "_donecyc4"}, at4, cycles(int'(tm), 4));
    chk({tag, "_ndone1"}, dc0, 1);
    chk({tag, "_ndone4"}, dc4, 1);
  endtask

  initial begin
    int bc0, bc4, f0, f4, dn;
    #2;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_res1", res0, 0);
    chk("rst_res4", res4, 0);
    @(negedge clk);
    rst = 1;
    run_op("t1_mul57", 4'd5, 4'd7, 2'd0, -1);
    run_op("t2_mul1515", 4'd15, 4'd15, 2'd0, -1);
    run_op("t2_mul09", 4'd0, 4'd9, 2'd0, -1);
    run_op("t3_min", 4'd9, 4'd4, 2'd1, -1);
    run_op("t3_max", 4'd9, 4'd4, 2'd2, -1);
    run_op("t3_mode3", 4'd3, 4'd3, 2'd3, -1);
    run_op("t4_ignstart", 4'd5, 4'd7, 2'd0, 10);
    bc0 = 0; bc4 = 0; f0 = 0; f4 = 0; dn = 0;
    go(4'd6, 4'd6, 2'd0);
    for (int c = 0; c < 300; c++) begin
      if (f4 == 1) begin chk("t5_abort_busy4", busy4, 0); chk("t5_abort_res4", res4, 35); f4 = 2; end
      if (f0 == 1) begin chk("t5_abort_busy1", busy0, 0); chk("t5_abort_res1", res0, 35); f0 = 2; end
      ab0 = 0; ab4 = 0;
      if (busy0) bc0++;
      if (busy4) bc4++;
      if (done0 || done4) dn++;
      if (bc4 == 30 && f4 == 0) begin ab4 = 1; f4 = 1; end
      if (bc0 == 100 && f0 == 0) begin ab0 = 1; f0 = 1; end
      if (f0 == 2 && f4 == 2) break;
      @(negedge clk);
    end
    ab0 = 0; ab4 = 0;
    repeat (3) begin
      @(negedge clk);
      if (done0 || done4 || busy0 || busy4) dn++;
    end
    chk("t5_abort_reached", f0 + f4, 4);
    chk("t5_no_done", dn, 0);
    run_op("t5_mul66", 4'd6, 4'd6, 2'd0, -1);
    go(4'd9, 4'd9, 2'd0);
    repeat (20) @(negedge clk);
    #3 rst = 0;
    #1;
    chk("t6_rst_busy1", busy0, 0);
    chk("t6_rst_busy4", busy4, 0);
    chk("t6_rst_done1", done0, 0);
    chk("t6_rst_res1", res0, 0);
    chk("t6_rst_res4", res4, 0);
    @(negedge clk);
    rst = 1;
    run_op("t6_mul23", 4'd2, 4'd3, 2'd0, -1);
    for (int k = 0; k < 6; k++)
      run_op("rnd", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
